t_ms_period_meter: RTL and testbench
====================================

Name: t_ms_period_meter

Overview:
- Downstream consumer of the T master-slave flip-flop.
- Samples the slave output, detects each toggle, and measures how many clk cycles each level was held.
- Delivers each completed interval as a one-entry valid/ready record, and keeps a running toggle count.
- Used to check divider/toggle behaviour in-system and to feed the result to a logger or comparator stage.

Parameters:
CNT_W, 16, width of interval length counter (saturating)
EDGE_W, 8, width of free-running toggle counter (wrapping)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset; 0 = reset asserted
qs_in  input  1  slave output of the T master-slave flip-flop
meas_ready  input  1  consumer accepts record when high with meas_valid
meas_valid  output  1  record available
meas_level  output  1  level (0/1) that the measured interval held
meas_len  output  CNT_W  interval length in clk cycles, 1..2^CNT_W-1
meas_ovf  output  1  interval reached saturation; meas_len = all ones
meas_lost  output  1  sticky: a completed interval was dropped under backpressure
edge_cnt  output  EDGE_W  toggles detected since reset, mod 2^EDGE_W

Behaviour:
- Reset (rst=0, async): all outputs 0, len counter 0, qs_d 0, FSM = PRIME; clears meas_lost.
- Edge detection:
  - qs_d registers the sampled qs_in each cycle.
  - edge = sampled qs_in XOR qs_d, evaluated only outside PRIME.
- FSM states PRIME, IDLE, MEASURE:
  - PRIME: first cycle after reset release. Load qs_d from the sample, then go to IDLE. No edge is evaluated, so a high qs_in at release is not a toggle.
  - IDLE: the current interval is partial and is never reported. On edge: edge_cnt+1, len=1, go to MEASURE.
  - MEASURE: len increments each cycle without an edge. It saturates at 2^CNT_W-1 and sets the internal ovf bit; it does not wrap.
  - MEASURE on edge:
    - Completed record = {level=qs_d, len, ovf}.
    - edge_cnt+1; len restarts at 1; ovf cleared; stay in MEASURE.
- Length convention: the edge cycle is cycle 1 of the new level. A level present for N sample cycles reports meas_len=N.
- Output latency: the record is registered and meas_valid rises the cycle after the edge is detected.
- Handshake (single output register):
  - Transfer occurs when meas_valid && meas_ready.
  - meas_valid and the record stay stable until transfer.
  - A record completing while meas_valid && !meas_ready is dropped: register unchanged, meas_lost set (sticky until reset).
  - A record completing in the same cycle as a transfer loads; meas_valid stays 1 with new data, no loss.
  - Transfer with no new record: meas_valid falls next cycle.
- edge_cnt wraps 2^EDGE_W-1 -> 0 with no flag.
- Reset mid-interval: the partial interval and any pending record are discarded; the FSM restarts at PRIME.

Optional Feature:
- Macro T_MS_PERIOD_SYNC_EN.
- Defined: qs_in passes through a 2-flop synchronizer (reset to 0) before qs_d. This permits an asynchronous qs_in. Edge detection and meas_valid shift 2 cycles later; meas_len values are unchanged. PRIME lasts 3 cycles so the synchronizer fills first.
- Undefined: qs_in is sampled directly and must be synchronous to clk; latency is as stated above.

Decomposition:
- Shared package t_ms_pkg:
  - FSM state enum (PRIME, IDLE, MEASURE).
  - Record struct {level, len, ovf} parameterized via CNT_W localparam default.
  - LEN_MAX constant.
- One natural sub-module: t_ms_edge_sync.
  - Contains the optional synchronizer, the qs_d register, and the edge/level outputs.
  - Instantiated once; keeps the macro confined to one file.

Test Plan:
- Reset release with qs_in=1 held 10 cycles -> no meas_valid, edge_cnt=0, FSM leaves PRIME in 1 cycle.
- After release: qs_in 0 for 3 cycles, 1 for 4, 0 for 6, 1 for 2, meas_ready=1 -> records {1,4,0} then {0,6,0}; edge_cnt=3; each meas_valid 1 cycle after its edge.
- CNT_W=4, qs_in held 1 for 20 cycles between toggles -> record {1,15,1}; next interval of 3 cycles -> {0,3,0}.
- meas_ready=0, qs_in toggling every 2 cycles -> first record held stable, meas_lost=1 after the 2nd completion. Raise meas_ready on the cycle a record completes -> old transfers, new loads, meas_valid stays 1.
- Assert rst mid-MEASURE with a pending record -> all outputs 0 asynchronously; after release the first interval is unreported.
- With T_MS_PERIOD_SYNC_EN, repeat scenario 2 -> same records, each meas_valid 2 cycles later.

Source files
------------

// File: rtl/t_ms_pkg.sv
// Shared types and constants for the T master-slave period meter.
// The record struct uses the default counter width; the top re-declares it when CNT_W is overridden.
package t_ms_pkg;

  typedef enum logic [1:0] {
    PRIME   = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int CNT_W_DEF  = 16;
  localparam int EDGE_W_DEF = 8;

  localparam logic [CNT_W_DEF-1:0] LEN_MAX = '1;

  typedef struct packed {
    logic                 level;
    logic [CNT_W_DEF-1:0] len;
    logic                 ovf;
  } rec_t;

endpackage

// File: rtl/t_ms_edge_sync.sv
// Input conditioning for the period meter: optional 2-flop synchronizer, qs_d history register.
// Optional macro T_MS_PERIOD_SYNC_EN enables the synchronizer and stretches priming to 3 cycles.
module t_ms_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic qs_in,
  output logic sample,
  output logic qs_d,
  output logic fill_done
);

`ifdef T_MS_PERIOD_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] fill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
      fill_q <= 2'd0;
    end else begin
      sync_q <= {sync_q[0], qs_in};
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
    end
  end

  // Priming ends once the synchronizer holds real samples, so no reset zero looks like a toggle.
  assign sample    = sync_q[1];
  assign fill_done = (fill_q == 2'd2);
`else
  assign sample    = qs_in;
  assign fill_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) qs_d <= 1'b0;
    else      qs_d <= sample;
  end

endmodule

// File: rtl/t_ms_period_meter.sv
// Measures how long each level of a T master-slave slave output is held and hands records out.
// Optional macro T_MS_PERIOD_SYNC_EN (handled in t_ms_edge_sync) allows an asynchronous qs_in.
module t_ms_period_meter
  import t_ms_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int EDGE_W = EDGE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              qs_in,
  input  logic              meas_ready,
  output logic              meas_valid,
  output logic              meas_level,
  output logic [CNT_W-1:0]  meas_len,
  output logic              meas_ovf,
  output logic              meas_lost,
  output logic [EDGE_W-1:0] edge_cnt
);

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] len;
    logic             ovf;
  } meas_rec_t;

  localparam logic [CNT_W-1:0] LEN_SAT = '1;

  logic sample, qs_d, fill_done;

  t_ms_edge_sync u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .qs_in     (qs_in),
    .sample    (sample),
    .qs_d      (qs_d),
    .fill_done (fill_done)
  );

  state_t            state, state_nxt;
  logic              edge_en, in_measure;
  logic              toggle, rec_done;
  logic [CNT_W-1:0]  len_q;
  logic              ovf_q;
  logic [EDGE_W-1:0] cnt_q;
  meas_rec_t         rec_q;
  logic              valid_q, lost_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= PRIME;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      PRIME:   if (fill_done) state_nxt = IDLE;
      IDLE:    if (toggle)    state_nxt = MEASURE;
      MEASURE: state_nxt = MEASURE;
      default: state_nxt = PRIME;
    endcase
  end

  always_comb begin
    edge_en    = 1'b0;
    in_measure = 1'b0;
    case (state)
      IDLE:    edge_en = 1'b1;
      MEASURE: begin
        edge_en    = 1'b1;
        in_measure = 1'b1;
      end
      default: ;
    endcase
  end

  assign toggle   = edge_en & (sample ^ qs_d);
  assign rec_done = in_measure & toggle;

  // The edge cycle counts as cycle 1 of the new level; the count sticks at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (toggle) begin
      len_q <= {{(CNT_W-1){1'b0}}, 1'b1};
      ovf_q <= 1'b0;
    end else if (in_measure) begin
      if (len_q != LEN_SAT)          len_q <= len_q + 1'b1;
      if (len_q >= LEN_SAT - 1'b1)   ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt_q <= '0;
    else if (toggle) cnt_q <= cnt_q + 1'b1;
  end

  // Single-entry output register: a finished record that finds it occupied and not draining is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_q   <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else if (rec_done) begin
      if (!valid_q || meas_ready) begin
        rec_q   <= '{level: qs_d, len: len_q, ovf: ovf_q};
        valid_q <= 1'b1;
      end else begin
        lost_q  <= 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign meas_valid = valid_q;
  assign meas_level = rec_q.level;
  assign meas_len   = rec_q.len;
  assign meas_ovf   = rec_q.ovf;
  assign meas_lost  = lost_q;
  assign edge_cnt   = cnt_q;

endmodule

// File: tb/tb_t_ms_period_meter.sv
// Randomized bench for t_ms_period_meter: qs_in is driven as runs of constant level and the
// expected records are derived from run lengths, then passed through a model of the output slot.
module tb_t_ms_period_meter;

  localparam int CNT_W   = 4;
  localparam int EDGE_W  = 4;
  localparam int LEN_MAX = (1 << CNT_W) - 1;
`ifdef T_MS_PERIOD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              clk;
  logic              rst;
  logic              qs_in;
  logic              meas_ready;
  logic              meas_valid;
  logic              meas_level;
  logic [CNT_W-1:0]  meas_len;
  logic              meas_ovf;
  logic              meas_lost;
  logic [EDGE_W-1:0] edge_cnt;

  t_ms_period_meter #(.CNT_W(CNT_W), .EDGE_W(EDGE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .qs_in      (qs_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .meas_level (meas_level),
    .meas_len   (meas_len),
    .meas_ovf   (meas_ovf),
    .meas_lost  (meas_lost),
    .edge_cnt   (edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Events seen by the sampling stage, delayed by the input pipeline latency.
  typedef struct {
    bit tog;
    bit rec;
    bit lvl;
    int len;
    bit ovf;
  } ev_t;

  ev_t evq[$];

  bit in_rst;
  bit primed;
  bit run_lvl;
  int run_len;
  int run_idx;
  bit exp_valid, exp_lvl, exp_ovf, exp_lost;
  int exp_len;
  int exp_cnt;

  task automatic model_clear();
    evq.delete();
    primed    = 0;
    run_lvl   = 0;
    run_len   = 0;
    run_idx   = 0;
    exp_valid = 0;
    exp_lvl   = 0;
    exp_len   = 0;
    exp_ovf   = 0;
    exp_lost  = 0;
    exp_cnt   = 0;
  endtask

  // One rising edge: q is the sampled level, r the ready level at that edge.
  task automatic model_edge(input bit q, input bit r);
    ev_t ev;
    if (in_rst) return;
    ev = '{tog: 0, rec: 0, lvl: 0, len: 0, ovf: 0};
    if (!primed) begin
      primed  = 1;
      run_lvl = q;
      run_len = 1;
      run_idx = 0;
    end else if (q != run_lvl) begin
      ev.tog = 1;
      if (run_idx >= 1) begin
        ev.rec = 1;
        ev.lvl = run_lvl;
        ev.len = (run_len > LEN_MAX) ? LEN_MAX : run_len;
        ev.ovf = (run_len >= LEN_MAX);
      end
      run_idx++;
      run_lvl = q;
      run_len = 1;
    end else begin
      run_len++;
    end
    evq.push_back(ev);
    if (evq.size() > LAT) begin
      ev = evq.pop_front();
      if (ev.tog) exp_cnt = (exp_cnt + 1) % (1 << EDGE_W);
      if (ev.rec) begin
        if (!exp_valid || r) begin
          exp_valid = 1;
          exp_lvl   = ev.lvl;
          exp_len   = ev.len;
          exp_ovf   = ev.ovf;
        end else begin
          exp_lost = 1;
        end
      end else if (exp_valid && r) begin
        exp_valid = 0;
      end
    end
  endtask

  task automatic compare();
    check("meas_valid", 32'(meas_valid), 32'(exp_valid));
    check("meas_lost",  32'(meas_lost),  32'(exp_lost));
    check("edge_cnt",   32'(edge_cnt),   32'(exp_cnt));
    if (exp_valid) begin
      check("meas_level", 32'(meas_level), 32'(exp_lvl));
      check("meas_len",   32'(meas_len),   32'(exp_len));
      check("meas_ovf",   32'(meas_ovf),   32'(exp_ovf));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_level"}, 32'(meas_level), 32'd0);
    check({tag, "_len"},   32'(meas_len),   32'd0);
    check({tag, "_ovf"},   32'(meas_ovf),   32'd0);
    check({tag, "_lost"},  32'(meas_lost),  32'd0);
    check({tag, "_cnt"},   32'(edge_cnt),   32'd0);
  endtask

  task automatic step(input bit q, input bit r);
    qs_in      = q;
    meas_ready = r;
    @(posedge clk);
    model_edge(q, r);
    @(negedge clk);
    compare();
  endtask

  // mode 0: ready low, 1: ready high, 2: ready high with probability pct percent
  task automatic run(input bit lvl, input int dur, input int mode, input int pct);
    bit r;
    for (int i = 0; i < dur; i++) begin
      r = (mode == 1) || (mode == 2 && $urandom_range(0, 99) < pct);
      step(lvl, r);
    end
  endtask

  // Called right after a negedge; asserts reset mid-cycle and releases it on a later negedge.
  task automatic do_reset(input int cycles);
    #2;
    rst    = 1'b0;
    in_rst = 1;
    #1;
    check_zero("async_rst");
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      compare();
    end
    rst    = 1'b1;
    in_rst = 0;
  endtask

  initial begin
    bit lvl;
    rst        = 1'b0;
    qs_in      = 1'b1;
    meas_ready = 1'b0;
    in_rst     = 1;
    model_clear();
    repeat (3) @(negedge clk);
    check_zero("por");
    rst    = 1'b1;
    in_rst = 0;

    // High at release is not a toggle and the partial first run is never reported.
    run(1, 10, 1, 0);

    do_reset(2);
    run(0, 3, 1, 0);
    run(1, 4, 1, 0);
    run(0, 6, 1, 0);
    run(1, 2, 1, 0);
    run(0, 3, 1, 0);

    // Saturation, then a short run after it.
    run(1, 20, 1, 0);
    run(0, 3, 1, 0);
    run(1, 15, 1, 0);
    run(0, 14, 1, 0);
    run(1, 2, 1, 0);

    // Backpressure: the held record stays put, later completions are dropped.
    lvl = 0;
    for (int i = 0; i < 6; i++) begin
      run(lvl, 2, 0, 0);
      lvl = !lvl;
    end
    for (int i = 0; i < 4; i++) begin
      run(lvl, 2, 1, 0);
      lvl = !lvl;
    end

    // Reset while measuring with a record pending.
    for (int i = 0; i < 4; i++) begin
      run(lvl, 3, 0, 0);
      lvl = !lvl;
    end
    run(lvl, 2, 0, 0);
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      run(lvl, 1 + i, 1, 0);
      lvl = !lvl;
    end

    // Random run lengths and ready patterns, including single-cycle runs.
    for (int round = 0; round < 4; round++) begin
      int pct;
      pct = (round == 0) ? 100 : (round == 1) ? 70 : (round == 2) ? 35 : 90;
      for (int s = 0; s < 40; s++) begin
        run(lvl, $urandom_range(1, 20), 2, pct);
        lvl = !lvl;
      end
      if (round == 2) do_reset(1 + round);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
